// File: rtl/countdown_timer.sv
// Loadable down-counter: accepts a value over a valid/ready handshake and pulses done at zero.
// Optional periodic mode under COUNTDOWN_AUTO_RELOAD_EN (adds reload_en input).
module countdown_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             enable,
    input  logic             abort,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic             reload_en,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_val_q, reload_val_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_val_d = reload_val_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_val_d = load_value;
`endif
                    if (load_value != '0) begin
                        count_d = load_value;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (enable) begin
                    // count is never 0 in RUN, so the else branch is the terminal count
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (reload_en) begin
                            count_d = reload_val_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
`else
                        count_d = '0;
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_val_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_val_q <= reload_val_d;
`endif
        end
    end

    assign count      = count_q;
    assign done       = done_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus directed corner sequences.
// Reload sequence is compiled only when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [4:0] lval;
        logic       en;
        logic       ab;
        logic [4:0] cnt;
        logic       bsy;
        logic       dn;
        logic       rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [4:0] load_value;
    logic       load_ready;
    logic       enable;
    logic       abort;
    logic [4:0] count;
    logic       busy;
    logic       done;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic       reload_en;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    countdown_timer #(.WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .enable     (enable),
        .abort      (abort),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .reload_en  (reload_en),
`endif
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void v(input logic r, input logic lv, input logic [4:0] lval,
                              input logic en, input logic ab, input logic [4:0] c,
                              input logic b, input logic d, input logic rd);
        vec_t t;
        t.rst = r; t.lv = lv; t.lval = lval; t.en = en; t.ab = ab;
        t.cnt = c; t.bsy = b; t.dn = d; t.rdy = rd;
        vecs.push_back(t);
    endfunction

    initial begin
        int  n;
        bit  seq_ok;
        rst = 1'b1; load_valid = 1'b0; load_value = '0; enable = 1'b0; abort = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_en = 1'b0;
`endif
        // reset state
        v(1,0,0,0,0, 0,0,0,1);
        v(1,0,0,0,0, 0,0,0,1);
        // load 5, count to zero
        v(0,1,5,1,0, 5,1,0,0);
        v(0,0,0,1,0, 4,1,0,0);
        v(0,0,0,1,0, 3,1,0,0);
        v(0,0,0,1,0, 2,1,0,0);
        v(0,0,0,1,0, 1,1,0,0);
        v(0,0,0,1,0, 0,0,1,1);
        v(0,0,0,1,0, 0,0,0,1);
        // reset mid-run at count 3
        v(0,1,5,1,0, 5,1,0,0);
        v(0,0,0,1,0, 4,1,0,0);
        v(0,0,0,1,0, 3,1,0,0);
        v(1,0,0,1,0, 0,0,0,1);
        v(0,0,0,0,0, 0,0,0,1);
        // load 3 with a 2-cycle pause at count 2
        v(0,1,3,0,0, 3,1,0,0);
        v(0,0,0,1,0, 2,1,0,0);
        v(0,0,0,0,0, 2,1,0,0);
        v(0,0,0,0,0, 2,1,0,0);
        v(0,0,0,1,0, 1,1,0,0);
        v(0,0,0,1,0, 0,0,1,1);
        // load 7, ignored reload while busy, then abort
        v(0,1,7,1,0, 7,1,0,0);
        v(0,1,4,1,0, 6,1,0,0);
        v(0,1,4,1,0, 5,1,0,0);
        v(0,0,0,1,0, 4,1,0,0);
        v(0,0,0,1,0, 3,1,0,0);
        v(0,0,0,1,0, 2,1,0,0);
        v(0,0,0,1,1, 0,0,0,1);
        v(0,0,0,1,1, 0,0,0,1);
        // zero-length loads, including back-to-back
        v(0,1,0,1,0, 0,0,1,1);
        v(0,0,0,0,0, 0,0,0,1);
        v(0,1,0,0,0, 0,0,1,1);
        v(0,1,0,0,0, 0,0,1,1);
        v(0,0,0,0,0, 0,0,0,1);
        // request held across terminal edge is taken on the next edge
        v(0,1,2,1,0, 2,1,0,0);
        v(0,0,0,1,0, 1,1,0,0);
        v(0,1,3,1,0, 0,0,1,1);
        v(0,1,3,1,0, 3,1,0,0);
        v(0,0,0,0,1, 0,0,0,1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; load_valid = vecs[i].lv; load_value = vecs[i].lval;
            enable = vecs[i].en; abort = vecs[i].ab;
            tick();
            check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].dn));
            check($sformatf("v%0d.ready", i), 32'(load_ready), 32'(vecs[i].rdy));
        end

        // full-range load of 31: done after exactly 31 enabled edges
        rst = 1'b0; abort = 1'b0; load_valid = 1'b1; load_value = 5'd31; enable = 1'b1;
        tick();
        check("max.load", 32'(count), 32'd31);
        load_valid = 1'b0;
        n = 0;
        seq_ok = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            if (done) break;
            if (count != 5'(31 - n) || !busy) seq_ok = 1'b0;
        end
        check("max.cycles", 32'(n), 32'd31);
        check("max.seq", 32'(seq_ok), 32'd1);
        check("max.end_count", 32'(count), 32'd0);
        check("max.end_busy", 32'(busy), 32'd0);
        tick();
        check("max.done_pulse", 32'(done), 32'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // periodic reload: 2,1,2,1,2 then drop reload_en to finish
        reload_en = 1'b1; load_valid = 1'b1; load_value = 5'd2; enable = 1'b1;
        tick();
        check("rl.load", 32'(count), 32'd2);
        load_valid = 1'b0;
        tick(); check("rl.c1", 32'(count), 32'd1); check("rl.d1", 32'(done), 32'd0);
        tick(); check("rl.c2", 32'(count), 32'd2); check("rl.d2", 32'(done), 32'd1);
        check("rl.b2", 32'(busy), 32'd1);
        tick(); check("rl.c3", 32'(count), 32'd1); check("rl.d3", 32'(done), 32'd0);
        tick(); check("rl.c4", 32'(count), 32'd2); check("rl.d4", 32'(done), 32'd1);
        reload_en = 1'b0;
        tick(); check("rl.c5", 32'(count), 32'd1);
        tick(); check("rl.c6", 32'(count), 32'd0); check("rl.d6", 32'(done), 32'd1);
        check("rl.b6", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
